rs232_rx: RTL and testbench

Serial-in, parallel-out receiver for the RS232 link; the receiving end of the 8-bit serialiser used on the transmit side. It oversamples the asynchronous `rxd` line and detects the start bit. It then samples eight data bits LSB-first at bit centres, checks the stop bit, and presents each received byte with a one-cycle `valid` strobe. It sits between the external RX pin and the byte-level consumer.

---
 rtl/rs232_rx.sv | 185 ++++++++++++++++++
 tb/tb_rs232_rx.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/rs232_rx.sv
// RS232 serial receiver: oversampled 8N1 (optionally 8E1) deserialiser with
// valid / frame_err / parity_err strobes. Optional parity via RS232_RX_PARITY_EN.
module rs232_rx #(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rxd,
   output logic [7:0] data,
   output logic       valid,
   output logic       frame_err,
   output logic       parity_err,
   output logic       busy
);

   localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] CNT_MID  = CW'(CLKS_PER_BIT / 2 - 1);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4,
      BREAK  = 3'd5
   } state_t;

   state_t          state_reg, state_next;
   logic [1:0]      sync_reg;
   logic            rxd_s;
   logic [CW-1:0]   cnt_reg, cnt_next;
   logic [2:0]      idx_reg, idx_next;
   logic [7:0]      sh_reg, sh_next;
   logic [7:0]      data_reg, data_next;
   logic            valid_reg, valid_next;
   logic            frame_err_reg, frame_err_next;
   logic            parity_err_next;
`ifdef RS232_RX_PARITY_EN
   logic            parity_err_reg;
   logic            par_bad_reg, par_bad_next;
`endif

   // Two-flop synchroniser; resets to the idle (mark) level
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) sync_reg <= 2'b11;
      else      sync_reg <= {sync_reg[0], rxd};
   end
   assign rxd_s = sync_reg[1];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg     <= IDLE;
         cnt_reg       <= '0;
         idx_reg       <= '0;
         sh_reg        <= '0;
         data_reg      <= '0;
         valid_reg     <= 1'b0;
         frame_err_reg <= 1'b0;
      end else begin
         state_reg     <= state_next;
         cnt_reg       <= cnt_next;
         idx_reg       <= idx_next;
         sh_reg        <= sh_next;
         data_reg      <= data_next;
         valid_reg     <= valid_next;
         frame_err_reg <= frame_err_next;
      end
   end

`ifdef RS232_RX_PARITY_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         parity_err_reg <= 1'b0;
         par_bad_reg    <= 1'b0;
      end else begin
         parity_err_reg <= parity_err_next;
         par_bad_reg    <= par_bad_next;
      end
   end
`endif

   always_comb begin
      state_next      = state_reg;
      cnt_next        = cnt_reg;
      idx_next        = idx_reg;
      sh_next         = sh_reg;
      data_next       = data_reg;
      valid_next      = 1'b0;
      frame_err_next  = 1'b0;
      parity_err_next = 1'b0;
`ifdef RS232_RX_PARITY_EN
      par_bad_next    = par_bad_reg;
`endif
      case (state_reg)
         IDLE: begin
            cnt_next = '0;
            if (!rxd_s) state_next = START;
         end
         START: begin
            if (cnt_reg == CNT_MID) begin
               cnt_next = '0;
               if (rxd_s) begin
                  state_next = IDLE;
               end else begin
                  idx_next   = '0;
                  state_next = DATA;
               end
            end else begin
               cnt_next = cnt_reg + 1'b1;
            end
         end
         DATA: begin
            if (cnt_reg == CNT_LAST) begin
               cnt_next = '0;
               sh_next  = {rxd_s, sh_reg[7:1]};
               if (idx_reg == 3'd7) begin
`ifdef RS232_RX_PARITY_EN
                  state_next = PARITY;
`else
                  state_next = STOP;
`endif
               end else begin
                  idx_next = idx_reg + 3'd1;
               end
            end else begin
               cnt_next = cnt_reg + 1'b1;
            end
         end
`ifdef RS232_RX_PARITY_EN
         PARITY: begin
            // Even parity: the parity bit equals the XOR of the data bits
            if (cnt_reg == CNT_LAST) begin
               cnt_next     = '0;
               par_bad_next = (rxd_s != ^sh_reg);
               state_next   = STOP;
            end else begin
               cnt_next = cnt_reg + 1'b1;
            end
         end
`endif
         STOP: begin
            if (cnt_reg == CNT_LAST) begin
               cnt_next = '0;
               if (rxd_s) begin
                  state_next = IDLE;
`ifdef RS232_RX_PARITY_EN
                  if (par_bad_reg) begin
                     parity_err_next = 1'b1;
                  end else begin
                     data_next  = sh_reg;
                     valid_next = 1'b1;
                  end
`else
                  data_next  = sh_reg;
                  valid_next = 1'b1;
`endif
               end else begin
                  frame_err_next = 1'b1;
                  state_next     = BREAK;
               end
            end else begin
               cnt_next = cnt_reg + 1'b1;
            end
         end
         BREAK: begin
            // Hold off until the line returns to mark so a stuck-low line cannot retrigger
            if (rxd_s) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   assign data      = data_reg;
   assign valid     = valid_reg;
   assign frame_err = frame_err_reg;
   assign busy      = (state_reg != IDLE);
`ifdef RS232_RX_PARITY_EN
   assign parity_err = parity_err_reg;
`else
   assign parity_err = 1'b0;
   wire unused_ok = &{1'b0, parity_err_next};
`endif

endmodule

// File: tb/tb_rs232_rx.sv
// Directed bench for rs232_rx: frame timing, back-to-back, false start, break,
// mid-frame reset and (with RS232_RX_PARITY_EN) parity checking.
module tb_rs232_rx;

   localparam int C = 16;
   localparam int H = C / 2;
`ifdef RS232_RX_PARITY_EN
   localparam int NBITS = 11;
`else
   localparam int NBITS = 10;
`endif
   localparam int LAT = H + (NBITS - 1) * C;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       rxd = 1'b1;
   logic [7:0] data;
   logic       valid;
   logic       frame_err;
   logic       parity_err;
   logic       busy;

   int n_vec = 0;
   int n_err = 0;

   rs232_rx #(.CLKS_PER_BIT(C)) dut (
      .clk        (clk),
      .rst        (rst),
      .rxd        (rxd),
      .data       (data),
      .valid      (valid),
      .frame_err  (frame_err),
      .parity_err (parity_err),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   // Event monitor: counts posedges and logs strobes and busy edges
   int         cyc = 0;
   int         v_cnt = 0, fe_cnt = 0, pe_cnt = 0, both_cnt = 0;
   int         v_cyc[$];
   logic [7:0] v_dat[$];
   int         t0_q[$];
   int         fall_q[$];
   logic       busy_q = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (valid) begin
         v_cnt++;
         v_cyc.push_back(cyc);
         v_dat.push_back(data);
      end
      if (frame_err) fe_cnt++;
      if (parity_err) pe_cnt++;
      if (valid && frame_err) both_cnt++;
      if (busy && !busy_q) t0_q.push_back(cyc);
      if (!busy && busy_q) fall_q.push_back(cyc);
      busy_q = busy;
   end

   task automatic drive_bit(input logic v);
      rxd = v;
      repeat (C) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop_v);
      drive_bit(1'b0);
      for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef RS232_RX_PARITY_EN
      drive_bit(^b);
`endif
      drive_bit(stop_v);
   endtask

   task automatic test_reset;
      rst = 1'b0;
      rxd = 1'b1;
      repeat (3) @(negedge clk);
      n_vec++; if (data !== 8'h00) begin n_err++; $display("FAIL reset_data: got %h expected 00", data); end
      n_vec++; if (valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b expected 0", valid); end
      n_vec++; if (frame_err !== 1'b0) begin n_err++; $display("FAIL reset_frame_err: got %b expected 0", frame_err); end
      n_vec++; if (parity_err !== 1'b0) begin n_err++; $display("FAIL reset_parity_err: got %b expected 0", parity_err); end
      n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy); end
      rst = 1'b1;
      repeat (4) @(negedge clk);
      $display("test_reset done");
   endtask

   task automatic test_a5;
      int vb = v_cnt, tb0 = t0_q.size(), fb = fall_q.size();
      int lat, fall_d;
      logic [7:0] got;
      send_frame(8'hA5, 1'b1);
      drive_bit(1'b1);
      got    = (v_dat.size() > vb) ? v_dat[vb] : 8'hxx;
      lat    = (v_cyc.size() > vb && t0_q.size() > tb0) ? v_cyc[vb] - t0_q[tb0] : -1;
      fall_d = (v_cyc.size() > vb && fall_q.size() > fb) ? fall_q[fb] - v_cyc[vb] : -1;
      n_vec++; if (v_cnt - vb !== 1) begin n_err++; $display("FAIL a5_valid_count: got %0d expected 1", v_cnt - vb); end
      n_vec++; if (got !== 8'hA5) begin n_err++; $display("FAIL a5_data: got %h expected a5", got); end
      n_vec++; if (lat !== LAT) begin n_err++; $display("FAIL a5_latency: got %0d expected %0d", lat, LAT); end
      n_vec++; if (fall_d !== 0) begin n_err++; $display("FAIL a5_busy_fall: got %0d expected 0", fall_d); end
      $display("test_a5: data=%h latency=%0d", got, lat);
   endtask

   task automatic test_back_to_back;
      int vb = v_cnt, gap;
      logic [7:0] d0, d1;
      send_frame(8'h00, 1'b1);
      send_frame(8'hFF, 1'b1);
      drive_bit(1'b1);
      d0  = (v_dat.size() > vb) ? v_dat[vb] : 8'hxx;
      d1  = (v_dat.size() > vb + 1) ? v_dat[vb+1] : 8'hxx;
      gap = (v_cyc.size() > vb + 1) ? v_cyc[vb+1] - v_cyc[vb] : -1;
      n_vec++; if (v_cnt - vb !== 2) begin n_err++; $display("FAIL b2b_valid_count: got %0d expected 2", v_cnt - vb); end
      n_vec++; if (d0 !== 8'h00) begin n_err++; $display("FAIL b2b_data0: got %h expected 00", d0); end
      n_vec++; if (d1 !== 8'hFF) begin n_err++; $display("FAIL b2b_data1: got %h expected ff", d1); end
      n_vec++; if (gap !== NBITS * C) begin n_err++; $display("FAIL b2b_gap: got %0d expected %0d", gap, NBITS * C); end
      $display("test_back_to_back: %h %h gap=%0d", d0, d1, gap);
   endtask

   task automatic test_false_start;
      int vb = v_cnt, feb = fe_cnt, tb0 = t0_q.size(), fb = fall_q.size();
      int dur;
      rxd = 1'b0;
      repeat (4) @(negedge clk);
      rxd = 1'b1;
      repeat (3 * C) @(negedge clk);
      dur = (t0_q.size() > tb0 && fall_q.size() > fb) ? fall_q[fb] - t0_q[tb0] : -1;
      n_vec++; if ((v_cnt - vb) + (fe_cnt - feb) !== 0) begin n_err++; $display("FAIL false_start_strobe: got %0d expected 0", (v_cnt - vb) + (fe_cnt - feb)); end
      n_vec++; if (data !== 8'hFF) begin n_err++; $display("FAIL false_start_data: got %h expected ff", data); end
      n_vec++; if (dur !== H) begin n_err++; $display("FAIL false_start_busy: got %0d expected %0d", dur, H); end
      $display("test_false_start: busy_cycles=%0d", dur);
   endtask

   task automatic test_break;
      int vb = v_cnt, feb = fe_cnt;
      logic [7:0] got;
      send_frame(8'h3C, 1'b0);
      repeat (30) drive_bit(1'b0);
      n_vec++; if (fe_cnt - feb !== 1) begin n_err++; $display("FAIL break_frame_err: got %0d expected 1", fe_cnt - feb); end
      n_vec++; if (v_cnt - vb !== 0) begin n_err++; $display("FAIL break_valid: got %0d expected 0", v_cnt - vb); end
      n_vec++; if (data !== 8'hFF) begin n_err++; $display("FAIL break_data: got %h expected ff", data); end
      n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL break_busy_held: got %b expected 1", busy); end
      drive_bit(1'b1);
      n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL break_busy_release: got %b expected 0", busy); end
      vb = v_cnt;
      send_frame(8'h11, 1'b1);
      drive_bit(1'b1);
      got = (v_dat.size() > vb) ? v_dat[vb] : 8'hxx;
      n_vec++; if (v_cnt - vb !== 1) begin n_err++; $display("FAIL break_next_count: got %0d expected 1", v_cnt - vb); end
      n_vec++; if (got !== 8'h11) begin n_err++; $display("FAIL break_next_data: got %h expected 11", got); end
      n_vec++; if (both_cnt !== 0) begin n_err++; $display("FAIL valid_with_frame_err: got %0d expected 0", both_cnt); end
      $display("test_break: frame_errs=%0d next=%h", fe_cnt - feb, got);
   endtask

   task automatic test_reset_mid;
      int vb;
      logic [7:0] b = 8'hC3;
      logic [7:0] got;
      drive_bit(1'b0);
      for (int i = 0; i < 4; i++) drive_bit(b[i]);
      rxd = b[4];
      repeat (H) @(negedge clk);
      rst = 1'b0;
      rxd = 1'b1;
      #1;
      n_vec++; if (data !== 8'h00) begin n_err++; $display("FAIL midrst_data: got %h expected 00", data); end
      n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL midrst_busy: got %b expected 0", busy); end
      repeat (3) @(negedge clk);
      n_vec++; if ({valid, frame_err, parity_err} !== 3'b000) begin n_err++; $display("FAIL midrst_strobes: got %b expected 000", {valid, frame_err, parity_err}); end
      rst = 1'b1;
      drive_bit(1'b1);
      vb = v_cnt;
      send_frame(8'h5A, 1'b1);
      drive_bit(1'b1);
      got = (v_dat.size() > vb) ? v_dat[vb] : 8'hxx;
      n_vec++; if (v_cnt - vb !== 1) begin n_err++; $display("FAIL midrst_next_count: got %0d expected 1", v_cnt - vb); end
      n_vec++; if (got !== 8'h5A) begin n_err++; $display("FAIL midrst_next_data: got %h expected 5a", got); end
      $display("test_reset_mid: next=%h", got);
   endtask

`ifdef RS232_RX_PARITY_EN
   task automatic send_frame_par(input logic [7:0] b, input logic par_v);
      drive_bit(1'b0);
      for (int i = 0; i < 8; i++) drive_bit(b[i]);
      drive_bit(par_v);
      drive_bit(1'b1);
   endtask

   task automatic test_parity;
      int vb = v_cnt, pb = pe_cnt;
      logic [7:0] got;
      send_frame_par(8'h07, 1'b1);
      drive_bit(1'b1);
      got = (v_dat.size() > vb) ? v_dat[vb] : 8'hxx;
      n_vec++; if (v_cnt - vb !== 1) begin n_err++; $display("FAIL parity_good_valid: got %0d expected 1", v_cnt - vb); end
      n_vec++; if (got !== 8'h07) begin n_err++; $display("FAIL parity_good_data: got %h expected 07", got); end
      n_vec++; if (pe_cnt - pb !== 0) begin n_err++; $display("FAIL parity_good_err: got %0d expected 0", pe_cnt - pb); end
      vb = v_cnt;
      send_frame_par(8'h07, 1'b0);
      drive_bit(1'b1);
      n_vec++; if (pe_cnt - pb !== 1) begin n_err++; $display("FAIL parity_bad_err: got %0d expected 1", pe_cnt - pb); end
      n_vec++; if (v_cnt - vb !== 0) begin n_err++; $display("FAIL parity_bad_valid: got %0d expected 0", v_cnt - vb); end
      $display("test_parity: good=%h bad_errs=%0d", got, pe_cnt - pb);
   endtask
`endif

   initial begin
      test_reset;
      test_a5;
      test_back_to_back;
      test_false_start;
      test_break;
      test_reset_mid;
`ifdef RS232_RX_PARITY_EN
      test_parity;
`endif
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
